// File: rtl/a2d_pkg.sv
// a2d_pkg: shared definitions for the A2D request arbiter.
//   A2D_RES_W    - conversion result width
//   A2D_CHNNL_W  - A2D channel select width
//   a2d_state_e  - arbiter FSM states
//   idx_w()      - index width for an N-entry vector (never below 1)
package a2d_pkg;
  localparam int A2D_RES_W   = 12;
  localparam int A2D_CHNNL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } a2d_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/a2d_arb_rr_sel.sv
// rr_sel: round-robin winner select.
//   req_i  - request vector
//   ptr_i  - index of the last granted requester
//   gnt_o  - one-hot winner (zero when no request)
//   idx_o  - winner index
// The search starts at ptr_i+1 and wraps from NUM_REQ-1 to 0.
module rr_sel
  import a2d_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic found;

  // For each distance off from the pointer, exactly one requester i sits
  // at (ptr+off) mod NUM_REQ; the first requesting one wins. Comparing
  // against both i and i+NUM_REQ keeps the wrap free of a modulo.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            ((int'(ptr_i) + off == i) || (int'(ptr_i) + off == i + NUM_REQ))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/a2d_arb.sv
// a2d_arb: round-robin arbiter sharing one A2D converter among NUM_REQ
// requesters. Optional conversion watchdog enabled by A2D_ARB_TMO_EN.
//   clk, rst           - clock, synchronous active-high reset
//   req, req_chnnl     - per-requester request and channel (3 bits each)
//   gnt, done          - one-hot grant, one-cycle one-hot completion pulse
//   res, err           - result (held until next done), timeout pulse
//   strt_cnv, chnnl    - start pulse and channel to the A2D
//   cnv_cmplt, a2d_res - completion and result from the A2D
module a2d_arb
  import a2d_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [A2D_CHNNL_W*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [A2D_RES_W-1:0]           res,
  output logic                           err,
  output logic                           strt_cnv,
  output logic [A2D_CHNNL_W-1:0]         chnnl,
  input  logic                           cnv_cmplt,
  input  logic [A2D_RES_W-1:0]           a2d_res
);
  localparam int IDX_W = idx_w(NUM_REQ);

  a2d_state_e                   state_q, state_d;
  logic [NUM_REQ-1:0]           gnt_q, gnt_d;
  logic [IDX_W-1:0]             ptr_q, ptr_d;
  logic [A2D_CHNNL_W-1:0]       chnnl_q, chnnl_d;
  logic [A2D_RES_W-1:0]         res_q, res_d;
  logic [NUM_REQ-1:0]           win_gnt;
  logic [IDX_W-1:0]             win_idx;
  logic [NUM_REQ-1:0][A2D_CHNNL_W-1:0] chn_arr;

  assign chn_arr = req_chnnl;

  rr_sel #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_sel (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

`ifdef A2D_ARB_TMO_EN
  localparam int CNT_W = idx_w(TMO_CYC);
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  // tmo_q is 0 in the first WAIT cycle, so this fires in WAIT cycle TMO_CYC.
  assign tmo_hit = (tmo_q == CNT_W'(TMO_CYC - 1));
  assign err     = err_q;
`else
  assign err = 1'b0;
  // TMO_CYC only matters with the watchdog built in.
  if (TMO_CYC > 0) begin : g_tmo_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
`ifdef A2D_ARB_TMO_EN
    tmo_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = START;
          gnt_d   = win_gnt;
          ptr_d   = win_idx;
          chnnl_d = chn_arr[win_idx];
        end
      end
      START: state_d = WAIT;
      WAIT: begin
`ifdef A2D_ARB_TMO_EN
        tmo_d = tmo_q + 1'b1;
`endif
        if (cnv_cmplt) begin
          res_d   = a2d_res;
          state_d = DONE;
        end
`ifdef A2D_ARB_TMO_EN
        else if (tmo_hit) begin
          res_d   = '1;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
`ifdef A2D_ARB_TMO_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      chnnl_q <= '0;
      res_q   <= '0;
`ifdef A2D_ARB_TMO_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
`ifdef A2D_ARB_TMO_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign done     = (state_q == DONE) ? gnt_q : '0;
  assign strt_cnv = (state_q == START);
  assign chnnl    = chnnl_q;
  assign res      = res_q;
endmodule

// File: doc/a2d_arb.md
A2D_ARB -- requirements
Module: a2d_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TMO_CYC, default 1024, the cnv_cmplt watchdog limit in clk cycles (used only with A2D_ARB_TMO_EN).
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester conversion request; held high until the matching done pulse.
REQ-006 req_chnnl  input  3*NUM_REQ  requested A2D channel; slice i belongs to requester i.
REQ-007 gnt  output  NUM_REQ  one-hot grant; at most one bit high.
REQ-008 done  output  NUM_REQ  one-cycle one-hot completion pulse to the granted requester.
REQ-009 res  output  12  conversion result; valid in the done cycle and held until the next done.
REQ-010 err  output  1  one-cycle pulse, coincident with done, marking a timed-out conversion.
REQ-011 strt_cnv  output  1  one-cycle start pulse to the A2D interface.
REQ-012 chnnl  output  3  channel presented to the A2D interface.
REQ-013 cnv_cmplt  input  1  A2D conversion complete.
REQ-014 a2d_res  input  12  A2D result; valid while cnv_cmplt=1.

Function
REQ-015 The FSM SHALL have four states: IDLE, START, WAIT and DONE.
REQ-016 IDLE->START SHALL occur when any req bit is high; the winner is chosen round-robin starting at the index after the last granted requester (requester 0 first after reset).
REQ-017 On the IDLE->START edge, gnt SHALL be registered to the winner, chnnl SHALL be latched from the winner's req_chnnl, and both SHALL hold until leaving DONE.
REQ-018 In START, strt_cnv SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-019 In WAIT, cnv_cmplt=1 SHALL capture a2d_res into res and move the FSM to DONE.
REQ-020 In DONE, done[granted]=1 for one cycle; gnt SHALL clear next cycle and the FSM SHALL return to IDLE.
REQ-021 Minimum latency SHALL be: req seen in IDLE -> strt_cnv 1 cycle later -> done 1 cycle after the cnv_cmplt cycle; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-022 A req that drops while granted SHALL NOT abort the conversion; the done pulse SHALL still be issued.
REQ-023 A cnv_cmplt seen outside WAIT SHALL be ignored.
REQ-024 Requests arriving at the same time SHALL be resolved by round-robin order only; a requester SHALL never be starved beyond NUM_REQ-1 other grants.
REQ-025 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-026 While rst=1: state=IDLE, gnt=0, done=0, err=0, strt_cnv=0, chnnl=0, res=0, RR pointer=NUM_REQ-1 (so requester 0 has priority).
REQ-027 Reset asserted mid-conversion SHALL abandon the conversion without a done pulse; a late cnv_cmplt after reset SHALL be ignored per REQ-023.

Configuration
REQ-028 With A2D_ARB_TMO_EN defined, a counter SHALL run in WAIT; reaching TMO_CYC cycles without cnv_cmplt SHALL go to DONE with res=12'hFFF and err=1 alongside done.
REQ-029 Without A2D_ARB_TMO_EN, WAIT SHALL wait indefinitely, err SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-030 The state enum (IDLE/START/WAIT/DONE), A2D_RES_W=12 and A2D_CHNNL_W=3 SHALL live in a shared package, a2d_pkg.
REQ-031 The round-robin selection SHALL be a separate sub-module, rr_sel (inputs: req, last-grant pointer; output: one-hot winner plus index).

Verification
REQ-032 Single req[2] with chnnl 3'd5; cnv_cmplt after 10 cycles with a2d_res=12'hABC -> strt_cnv 1 cycle after req, chnnl=5, done=4'b0100 with res=12'hABC.
REQ-033 req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each done one-hot and matching gnt.
REQ-034 req[1] dropped during WAIT -> conversion completes and done[1] still pulses; no new grant to requester 1 afterwards.
REQ-035 rst pulsed during WAIT, then cnv_cmplt -> no done, all outputs at their reset values, next req[0] starts a fresh conversion.
REQ-036 With A2D_ARB_TMO_EN and TMO_CYC=16, no cnv_cmplt -> 16 cycles into WAIT, done and err pulse with res=12'hFFF.
REQ-037 cnv_cmplt pulsed in IDLE with no req -> no state change and res unchanged.
